// File: rtl/fp_pkg.sv
// Shared types and width helpers for the fp_unpack_pipe slice.
//   fp_class_e : 3-bit operand class reported per lane (also the index
//                of the per-class statistics counters)
//   fp_bias    : exponent bias for a given exponent field width
//   fp_man_bit : stored mantissa field width
//   fp_exp_w   : width of the signed unbiased exponent output
//   fp_lzc_w   : leading-zero count width for a mantissa field
package fp_pkg;

  typedef enum logic [2:0] {
    FP_ZERO   = 3'd0,
    FP_DENORM = 3'd1,
    FP_NORMAL = 3'd2,
    FP_INF    = 3'd3,
    FP_QNAN   = 3'd4,
    FP_SNAN   = 3'd5
  } fp_class_e;

  function automatic int fp_bias(input int exp_bit);
    return (1 << (exp_bit - 1)) - 1;
  endfunction

  function automatic int fp_man_bit(input int n_bit, input int exp_bit);
    return n_bit - exp_bit - 1;
  endfunction

  // Two extra bits give headroom for the most negative denormal exponent
  // plus the sign.
  function automatic int fp_exp_w(input int exp_bit);
    return exp_bit + 2;
  endfunction

  // Wide enough to hold a count of 0..w; never narrower than 5 bits.
  function automatic int fp_lzc_w(input int w);
    int c;
    c = $clog2(w + 1);
    return (c < 5) ? 5 : c;
  endfunction

endpackage

// File: rtl/fp_unpack_pipe_if.sv
// Handshake and data bundle for fp_unpack_pipe.
//   in_valid/in_ready/in_value           : input vector, LANES*N_BIT packed
//   out_valid/out_ready                  : output handshake
//   out_sign/out_exp/out_man/out_class   : per-lane unpacked results
//   stats_clr/stats_cnt                  : present only with FP_UNPACK_STATS_EN
// Modports: slave = the unpacker, master = the producer/consumer side.
interface fp_unpack_pipe_if #(
  parameter int N_BIT   = 32,
  parameter int EXP_BIT = 8,
  parameter int LANES   = 1,
  parameter int CNT_W   = 16
);
  localparam int MAN_BIT = N_BIT - EXP_BIT - 1;
  localparam int EXP_W   = EXP_BIT + 2;

  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*N_BIT-1:0]       in_value;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES-1:0]             out_sign;
  logic [LANES*EXP_W-1:0]       out_exp;
  logic [LANES*(MAN_BIT+1)-1:0] out_man;
  logic [LANES*3-1:0]           out_class;
`ifdef FP_UNPACK_STATS_EN
  logic                         stats_clr;
  logic [6*CNT_W-1:0]           stats_cnt;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fp_unpack_pipe_if: CNT_W must be at least 1");
  end

  modport slave (
    input  in_valid, in_value, out_ready,
`ifdef FP_UNPACK_STATS_EN
    input  stats_clr,
    output stats_cnt,
`endif
    output in_ready, out_valid, out_sign, out_exp, out_man, out_class
  );

  modport master (
    output in_valid, in_value, out_ready,
`ifdef FP_UNPACK_STATS_EN
    output stats_clr,
    input  stats_cnt,
`endif
    input  in_ready, out_valid, out_sign, out_exp, out_man, out_class
  );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//   i_vec : W-bit input
//   o_cnt : number of zeros above the highest set bit (W when i_vec is 0)
module fp_lzc #(
  parameter int W  = 23,
  parameter int CW = 5
) (
  input  logic [W-1:0]  i_vec,
  output logic [CW-1:0] o_cnt
);

  logic w_found;

  always_comb begin
    o_cnt   = CW'(W);
    w_found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!w_found && i_vec[W-1-i]) begin
        o_cnt   = CW'(i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_unpack_pipe.sv
// Multi-lane two-stage IEEE-754 unpacker/classifier.
// Stage 1 registers the field decode, class and mantissa leading-zero
// count; stage 2 registers the normalised mantissa and signed unbiased
// exponent. Denormals leave with a hidden 1 and a correspondingly lower
// exponent. All lanes share one valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fp_unpack_pipe_if.slave (input/output handshakes, per-lane
//          results, optional statistics)
// Optional feature: define FP_UNPACK_STATS_EN to add saturating per-class
// counters of output lane-results, with synchronous clear (clear wins).
module fp_unpack_pipe
  import fp_pkg::*;
#(
  parameter int N_BIT   = 32,
  parameter int EXP_BIT = 8,
  parameter int LANES   = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  fp_unpack_pipe_if.slave  bus
);

  localparam int MAN_BIT = fp_man_bit(N_BIT, EXP_BIT);
  localparam int EXP_W   = fp_exp_w(EXP_BIT);
  localparam int BIAS    = fp_bias(EXP_BIT);
  localparam int LZ_W    = fp_lzc_w(MAN_BIT);

  localparam logic [EXP_W-1:0] BIAS_V     = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] NEG_BIAS_V = EXP_W'(-BIAS);

  if (MAN_BIT + 1 >= (1 << (EXP_BIT - 1))) begin : g_bad_widths
    $error("fp_unpack_pipe: mantissa too wide for exponent range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fp_unpack_pipe: CNT_W must be at least 1");
  end

  // Shared handshake
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s1_adv;
  logic w_s2_adv;
  logic w_s1_load;
  logic w_s2_load;

  assign w_s2_adv  = !r_s2_valid || bus.out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_s1_load = w_s1_adv && bus.in_valid;
  assign w_s2_load = w_s2_adv && r_s1_valid;

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= bus.in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  // Per-lane datapath
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [N_BIT-1:0]   w_val;
    logic [EXP_BIT-1:0] w_e;
    logic [MAN_BIT-1:0] w_m;
    logic [LZ_W-1:0]    w_lzc;
    fp_class_e          w_cls;

    assign w_val = bus.in_value[l*N_BIT +: N_BIT];
    assign w_e   = w_val[N_BIT-2 -: EXP_BIT];
    assign w_m   = w_val[MAN_BIT-1:0];

    fp_lzc #(
      .W  (MAN_BIT),
      .CW (LZ_W)
    ) u_lzc (
      .i_vec (w_m),
      .o_cnt (w_lzc)
    );

    always_comb begin
      w_cls = FP_NORMAL;
      if (w_e == '0) begin
        if (w_m == '0) w_cls = FP_ZERO;
        else           w_cls = FP_DENORM;
      end else if (w_e == '1) begin
        if (w_m == '0)            w_cls = FP_INF;
        else if (w_m[MAN_BIT-1])  w_cls = FP_QNAN;
        else                      w_cls = FP_SNAN;
      end
    end

    logic               r_s1_sign;
    fp_class_e          r_s1_cls;
    logic [EXP_BIT-1:0] r_s1_e;
    logic [MAN_BIT-1:0] r_s1_m;
    logic [LZ_W-1:0]    r_s1_lzc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1_sign <= 1'b0;
        r_s1_cls  <= FP_ZERO;
        r_s1_e    <= '0;
        r_s1_m    <= '0;
        r_s1_lzc  <= '0;
      end else if (w_s1_load) begin
        r_s1_sign <= w_val[N_BIT-1];
        r_s1_cls  <= w_cls;
        r_s1_e    <= w_e;
        r_s1_m    <= w_m;
        r_s1_lzc  <= w_lzc;
      end
    end

    logic [EXP_W-1:0]   w_exp;
    logic [MAN_BIT:0]   w_man;

    // Denormal: shifting by lzc+1 pushes the leading 1 into the hidden
    // position; the exponent drops by the same lzc below -BIAS
    // (the denormal scale 2**(1-BIAS) minus one hidden-bit position).
    always_comb begin
      w_exp = '0;
      w_man = '0;
      unique case (r_s1_cls)
        FP_NORMAL: begin
          w_exp = EXP_W'(r_s1_e) - BIAS_V;
          w_man = {1'b1, r_s1_m};
        end
        FP_DENORM: begin
          w_exp = NEG_BIAS_V - EXP_W'(r_s1_lzc);
          w_man = {1'b0, r_s1_m} << (r_s1_lzc + LZ_W'(1));
        end
        FP_QNAN, FP_SNAN: begin
          w_man = {1'b1, r_s1_m};
        end
        default: begin
          w_exp = '0;
          w_man = '0;
        end
      endcase
    end

    logic               r_s2_sign;
    fp_class_e          r_s2_cls;
    logic [EXP_W-1:0]   r_s2_exp;
    logic [MAN_BIT:0]   r_s2_man;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s2_sign <= 1'b0;
        r_s2_cls  <= FP_ZERO;
        r_s2_exp  <= '0;
        r_s2_man  <= '0;
      end else if (w_s2_load) begin
        r_s2_sign <= r_s1_sign;
        r_s2_cls  <= r_s1_cls;
        r_s2_exp  <= w_exp;
        r_s2_man  <= w_man;
      end
    end

    assign bus.out_sign[l]                         = r_s2_sign;
    assign bus.out_class[l*3 +: 3]                 = r_s2_cls;
    assign bus.out_exp[l*EXP_W +: EXP_W]           = r_s2_exp;
    assign bus.out_man[l*(MAN_BIT+1) +: MAN_BIT+1] = r_s2_man;
  end

`ifdef FP_UNPACK_STATS_EN
  // Per-class counters of output lane-results
  localparam int SUM_W = CNT_W + $clog2(LANES + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic             w_out_fire;
  logic [CNT_W-1:0] r_cnt  [6];
  logic [SUM_W-1:0] w_sum  [6];
  logic [CNT_W-1:0] w_next [6];

  assign w_out_fire = r_s2_valid && bus.out_ready;

  // Lanes of the same class add together in one cycle, then saturate.
  always_comb begin
    for (int unsigned c = 0; c < 6; c++) begin
      w_sum[c] = SUM_W'(r_cnt[c]);
      for (int unsigned l = 0; l < LANES; l++) begin
        if (bus.out_class[l*3 +: 3] == 3'(c)) w_sum[c] = w_sum[c] + SUM_W'(1);
      end
      w_next[c] = (w_sum[c] > CNT_MAX) ? '1 : CNT_W'(w_sum[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < 6; c++) r_cnt[c] <= '0;
    end else if (bus.stats_clr) begin
      for (int unsigned c = 0; c < 6; c++) r_cnt[c] <= '0;
    end else if (w_out_fire) begin
      for (int unsigned c = 0; c < 6; c++) r_cnt[c] <= w_next[c];
    end
  end

  for (genvar c = 0; c < 6; c++) begin : g_cnt_out
    assign bus.stats_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
  end
`endif

endmodule

// File: tb/tb_fp_unpack_pipe.sv
module tb_fp_unpack_pipe;

  localparam int N_BIT   = 32;
  localparam int EXP_BIT = 8;
  localparam int LANES   = 2;
  localparam int CNT_W   = 4;
  localparam int MAN_BIT = N_BIT - EXP_BIT - 1;
  localparam int EXP_W   = EXP_BIT + 2;
  localparam int BIAS    = 127;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_unpack_pipe_if #(
    .N_BIT   (N_BIT),
    .EXP_BIT (EXP_BIT),
    .LANES   (LANES),
    .CNT_W   (CNT_W)
  ) bus ();

  fp_unpack_pipe #(
    .N_BIT   (N_BIT),
    .EXP_BIT (EXP_BIT),
    .LANES   (LANES),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        sign;
    int          cls;
    int          ex;
    logic [23:0] man;
  } ref_t;

  typedef struct {
    logic [63:0] val;
    int          acc;
    bit          latchk;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  occ      = 0;
`ifdef FP_UNPACK_STATS_EN
  logic clr_req = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: real-number view of the encoding. A denormal is
  // M * 2**(1-BIAS-MAN_BIT); its top set bit p becomes the hidden 1.
  function automatic ref_t ref_unpack(input logic [31:0] x);
    ref_t r;
    int e, p;
    logic [22:0] m;
    e = int'(x[30:23]);
    m = x[22:0];
    r.sign = x[31];
    r.ex   = 0;
    r.man  = '0;
    if (e == 0) begin
      if (m == 0) r.cls = 0;
      else begin
        r.cls = 1;
        p = 0;
        for (int b = 0; b < MAN_BIT; b++) if (m[b]) p = b;
        r.ex  = p - MAN_BIT + 1 - BIAS;
        r.man = 24'(m) << (MAN_BIT - p);
      end
    end else if (e == 255) begin
      if (m == 0) r.cls = 3;
      else begin
        r.cls = m[22] ? 4 : 5;
        r.man = {1'b1, m};
      end
    end else begin
      r.cls = 2;
      r.ex  = e - BIAS;
      r.man = {1'b1, m};
    end
    return r;
  endfunction

  task automatic compare(input sb_t s);
    ref_t r;
    logic signed [EXP_W-1:0] de;
    longint dl, rl;
    for (int l = 0; l < LANES; l++) begin
      r  = ref_unpack(s.val[l*32 +: 32]);
      de = bus.out_exp[l*EXP_W +: EXP_W];
      dl = de;
      rl = r.ex;
      chk($sformatf("L%0d.sign[%h]", l, s.val[l*32 +: 32]), bus.out_sign[l], r.sign);
      chk($sformatf("L%0d.class[%h]", l, s.val[l*32 +: 32]), bus.out_class[l*3 +: 3], r.cls);
      chk($sformatf("L%0d.exp[%h]", l, s.val[l*32 +: 32]), dl, rl);
      chk($sformatf("L%0d.man[%h]", l, s.val[l*32 +: 32]), bus.out_man[l*24 +: 24], r.man);
    end
  endtask

  task automatic cycle(input logic v, input logic [63:0] val, input logic ordy,
                       input bit latchk, output bit fired);
    @(negedge clk);
    cyc++;
    bus.in_valid  = v;
    bus.in_value  = val;
    bus.out_ready = ordy;
`ifdef FP_UNPACK_STATS_EN
    bus.stats_clr = clr_req;
`endif
    #1;
    chk("in_ready", bus.in_ready, (occ == 2 && !ordy) ? 0 : 1);
    if (occ == 0) chk("out_valid_idle", bus.out_valid, 0);
    if (bus.out_valid) begin
      if (sb.size() == 0) chk("spurious_out", bus.out_valid, 0);
      else begin
        compare(sb[0]);
        if (ordy) begin
          if (sb[0].latchk) chk("latency", cyc - sb[0].acc, 2);
          void'(sb.pop_front());
          occ--;
        end
      end
    end
    fired = v && bus.in_ready;
    if (fired) begin
      sb.push_back('{val, cyc, latchk});
      occ++;
    end
  endtask

  task automatic idle(input int n);
    bit f;
    for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, f);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    chk("drain_left", sb.size(), 0);
    idle(1);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [22:0] m;
    logic [7:0]  e;
    int sel;
    sel = $urandom_range(0, 5);
    m   = 23'($urandom);
    case (sel)
      0:       begin e = 8'h00; m = '0; end
      1:       begin e = 8'h00; m = m >> $urandom_range(0, 22); end
      2, 3:    e = 8'($urandom_range(1, 254));
      4:       e = 8'hFF;
      default: begin e = 8'hFF; if ($urandom_range(0, 1) == 1) m = '0; end
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  logic [63:0] directed [4];
  logic [63:0] stream [8];
  bit f;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b1;
`ifdef FP_UNPACK_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    // reset state
    @(negedge clk);
    #1;
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.in_ready", bus.in_ready, 1);
    chk("rst.out_sign", bus.out_sign, 0);
    chk("rst.out_exp", bus.out_exp, 0);
    chk("rst.out_man", bus.out_man, 0);
    chk("rst.out_class", bus.out_class, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed operands, lane1 in upper half
    directed[0] = {32'h80000000, 32'h3F800000};
    directed[1] = {32'h00400000, 32'h00000001};
    directed[2] = {32'h7FC00000, 32'h7F800000};
    directed[3] = {32'h3F800000, 32'h7F800001};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, directed[i], 1'b1, 1'b1, f);
      idle(3);
    end
    drain();

    // back-to-back stream with out_ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) stream[i] = {rnd_fp(), rnd_fp()};
    begin
      int idx = 0;
      int k = 0;
      while (idx < 8 && k < 100) begin
        cycle(1'b1, stream[idx], (k % 4 == 0 || k % 4 == 3), 1'b0, f);
        if (f) idx++;
        k++;
      end
      chk("stream_accepted", idx, 8);
    end
    drain();

    // reset with two vectors in flight
    cycle(1'b1, {32'h40490FDB, 32'h00000010}, 1'b0, 1'b0, f);
    cycle(1'b1, {32'h7F800000, 32'hC0000000}, 1'b0, 1'b0, f);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", bus.out_valid, 0);
    chk("midrst.in_ready", bus.in_ready, 1);
    sb.delete();
    occ = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    cycle(1'b1, {32'h00000003, 32'hBF000000}, 1'b1, 1'b1, f);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, {rnd_fp(), rnd_fp()}, $urandom_range(0, 2) != 0, 1'b0, f);
    drain();

    // full-throughput window: latency stays 2 with no bubbles
    for (int i = 0; i < 10; i++) cycle(1'b1, {rnd_fp(), rnd_fp()}, 1'b1, 1'b1, f);
    drain();

`ifdef FP_UNPACK_STATS_EN
    clr_req = 1'b1;
    idle(1);
    clr_req = 1'b0;
    idle(1);
    cycle(1'b1, {32'h00000001, 32'h7F800000}, 1'b1, 1'b0, f);
    drain();
    chk("stats.inf", bus.stats_cnt[3*CNT_W +: CNT_W], 1);
    chk("stats.denorm", bus.stats_cnt[1*CNT_W +: CNT_W], 1);
    chk("stats.normal0", bus.stats_cnt[2*CNT_W +: CNT_W], 0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, {32'h40000000 | 32'($urandom_range(0, 1000)), 32'hC1200000}, 1'b1, 1'b0, f);
    drain();
    chk("stats.normal_sat", bus.stats_cnt[2*CNT_W +: CNT_W], 15);
    chk("stats.zero", bus.stats_cnt[0*CNT_W +: CNT_W], 0);
    // clear in the same cycle as an output transfer
    cycle(1'b1, {32'h3F800000, 32'h80000000}, 1'b1, 1'b0, f);
    idle(1);
    clr_req = 1'b1;
    idle(1);
    clr_req = 1'b0;
    idle(1);
    chk("stats.clr_normal", bus.stats_cnt[2*CNT_W +: CNT_W], 0);
    chk("stats.clr_zero", bus.stats_cnt[0*CNT_W +: CNT_W], 0);
    chk("stats.clr_inf", bus.stats_cnt[3*CNT_W +: CNT_W], 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
